// File: rtl/mux_sel_scheduler.sv
// Round-robin select scheduler for a downstream 4:1 mux.
// It grants one of four requesting channels for a programmable dwell time, and every output is registered.
module mux_sel_scheduler #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [3:0]         req,
  input  logic [DWELL_W-1:0] dwell,
  output logic               sl1,
  output logic               sl2,
  output logic [3:0]         grant,
  output logic               busy,
  output logic               done
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state, next_state;
  logic [DWELL_W-1:0] cnt, next_cnt;
  logic [1:0]         last, next_last;
  logic [1:0]         sel, next_sel;
  logic [3:0]         next_grant;
  logic               next_busy, next_done;
  logic [1:0]         winner;

  // The first set request after 'last' wins. The loop scans from the farthest
  // candidate to the nearest, so the nearest set request is written last and wins.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] l);
    logic [1:0] w;
    logic [1:0] idx;
    w = l;
    for (int i = 4; i >= 1; i--) begin
      idx = l + 2'(i);
      if (r[idx]) w = idx;
    end
    return w;
  endfunction

  assign winner = pick(req, last);

  always_comb begin
    // NOTE: every signal gets a default before the case statement. This keeps synthesis from inferring latches on paths that do not assign it.
    next_state = state;
    next_cnt   = cnt;
    next_last  = last;
    next_sel   = sel;
    next_grant = grant;
    next_busy  = busy;
    next_done  = 1'b0;

    unique case (state)
      IDLE: begin
        if (en && req != 4'b0000) begin
          next_state = GRANT;
          next_sel   = winner;
          next_last  = winner;
          next_cnt   = dwell;
          next_busy  = 1'b1;
          next_grant = 4'b0001 << winner;
        end
      end
      GRANT: begin
        if (cnt == '0) begin
          // Normal completion wins over a simultaneous drop of the granted request.
          // The dropped channel is already low in req, so the winner search skips it.
          next_done = 1'b1;
          if (en && req != 4'b0000) begin
            next_sel   = winner;
            next_last  = winner;
            next_cnt   = dwell;
            next_grant = 4'b0001 << winner;
          end else begin
            next_state = IDLE;
            next_busy  = 1'b0;
            next_grant = 4'b0000;
          end
        end else if (!req[sel]) begin
          next_done  = 1'b1;
          next_state = IDLE;
          next_busy  = 1'b0;
          next_grant = 4'b0000;
        end else begin
          next_cnt = cnt - 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. Every flop then samples the values from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      last  <= 2'd3;
      sel   <= 2'd0;
      grant <= 4'b0000;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      last  <= next_last;
      sel   <= next_sel;
      grant <= next_grant;
      busy  <= next_busy;
      done  <= next_done;
    end
  end

  assign sl1 = sel[1];
  assign sl2 = sel[0];

endmodule

// File: tb/tb_mux_sel_scheduler.sv
// Self-checking bench for mux_sel_scheduler.
// It uses per-cycle vectors with hand-derived expected outputs, checked through a scoreboard queue.
module tb_mux_sel_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] req;
  logic [3:0] dwell;
  logic       sl1, sl2, busy, done;
  logic [3:0] grant;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       en;
    logic [3:0] req;
    logic [3:0] dwell;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       busy;
    logic       done;
    string      name;
  } vec_t;

  typedef struct {
    logic [7:0] exp;
    string      name;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];

  mux_sel_scheduler #(.DWELL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .dwell(dwell),
    .sl1(sl1), .sl2(sl2), .grant(grant), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic e, input logic [3:0] r, input logic [3:0] d,
                              input logic [1:0] s, input logic [3:0] g, input logic b,
                              input logic dn, input string nm);
    vec_t v;
    v.en = e; v.req = r; v.dwell = d; v.sel = s; v.grant = g; v.busy = b; v.done = dn; v.name = nm;
    vecs.push_back(v);
  endfunction

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {sel,grant,busy,done}=%b want %b", nm, act, exp);
    end
  endtask

  // Drive one vector and queue its expected outputs. After the next rising edge, pop and compare.
  task automatic apply(input vec_t v);
    sb_t e;
    en = v.en; req = v.req; dwell = v.dwell;
    e.exp  = {v.sel, v.grant, v.busy, v.done};
    e.name = v.name;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check(e.name, {sl1, sl2, grant, busy, done}, e.exp);
  endtask

  initial begin
    // Rotation through all four channels with dwell=1.
    add(1, 4'b1111, 1, 0, 4'b0001, 1, 0, "rr_start_ch0");
    add(1, 4'b1111, 1, 0, 4'b0001, 1, 0, "rr_ch0_2nd");
    add(1, 4'b1111, 1, 1, 4'b0010, 1, 1, "rr_ch1");
    add(1, 4'b1111, 1, 1, 4'b0010, 1, 0, "rr_ch1_2nd");
    add(1, 4'b1111, 1, 2, 4'b0100, 1, 1, "rr_ch2");
    add(1, 4'b1111, 1, 2, 4'b0100, 1, 0, "rr_ch2_2nd");
    add(1, 4'b1111, 1, 3, 4'b1000, 1, 1, "rr_ch3");
    add(1, 4'b1111, 1, 3, 4'b1000, 1, 0, "rr_ch3_2nd");
    add(1, 4'b1111, 1, 0, 4'b0001, 1, 1, "rr_wrap_ch0");
    add(0, 4'b0000, 1, 0, 4'b0000, 0, 1, "rr_abort");
    add(0, 4'b0000, 1, 0, 4'b0000, 0, 0, "rr_idle");
    // A single requester is re-granted with no gap cycle.
    add(1, 4'b0100, 3, 2, 4'b0100, 1, 0, "solo_start");
    for (int i = 0; i < 3; i++) add(1, 4'b0100, 3, 2, 4'b0100, 1, 0, "solo_hold");
    add(1, 4'b0100, 3, 2, 4'b0100, 1, 1, "solo_regrant");
    add(0, 4'b0000, 3, 2, 4'b0000, 0, 1, "solo_abort");
    add(0, 4'b0000, 3, 2, 4'b0000, 0, 0, "solo_idle");
    // Abort on channel 1, then no chaining: the next grant starts one edge after done.
    add(1, 4'b0010, 7, 1, 4'b0010, 1, 0, "ab_start");
    add(1, 4'b0010, 7, 1, 4'b0010, 1, 0, "ab_cyc2");
    add(1, 4'b0010, 7, 1, 4'b0010, 1, 0, "ab_cyc3");
    add(1, 4'b0001, 7, 1, 4'b0000, 0, 1, "ab_drop");
    add(1, 4'b0001, 7, 0, 4'b0001, 1, 0, "ab_next_ch0");
    add(0, 4'b0000, 7, 0, 4'b0000, 0, 1, "ab_abort2");
    add(0, 4'b0000, 0, 0, 4'b0000, 0, 0, "ab_idle");
    // Fairness starting from last=0.
    add(1, 4'b1001, 0, 3, 4'b1000, 1, 0, "fair_ch3");
    add(1, 4'b1011, 0, 0, 4'b0001, 1, 1, "fair_ch0");
    add(1, 4'b1011, 0, 1, 4'b0010, 1, 1, "fair_ch1");
    add(0, 4'b0000, 0, 1, 4'b0000, 0, 1, "fair_end");
    add(0, 4'b0000, 0, 1, 4'b0000, 0, 0, "fair_idle");
    // en drops mid-grant, and the full 5-cycle grant still completes.
    add(1, 4'b1000, 4, 3, 4'b1000, 1, 0, "en_start");
    for (int i = 0; i < 4; i++) add(0, 4'b1000, 4, 3, 4'b1000, 1, 0, "en_hold");
    add(0, 4'b1000, 4, 3, 4'b0000, 0, 1, "en_complete");
    add(0, 4'b1000, 4, 3, 4'b0000, 0, 0, "en_sel_holds");
    // Maximum dwell gives a 16-cycle grant. A dwell change mid-grant is ignored.
    add(1, 4'b0010, 15, 1, 4'b0010, 1, 0, "max_start");
    for (int i = 0; i < 15; i++) add(1, 4'b0010, 0, 1, 4'b0010, 1, 0, "max_hold");
    add(0, 4'b0010, 0, 1, 4'b0000, 0, 1, "max_complete");
    add(0, 4'b0000, 0, 1, 4'b0000, 0, 0, "max_idle");

    en = 1'b0; req = 4'b0000; dwell = 4'd0;
    rst_n = 1'b0;
    #12;
    check("reset_outputs", {sl1, sl2, grant, busy, done}, 8'b0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) apply(vecs[i]);

    // Reset asserted mid-grant clears every output before the next edge.
    begin
      vec_t v;
      v.en = 1; v.req = 4'b0100; v.dwell = 4'd5; v.sel = 2; v.grant = 4'b0100; v.busy = 1; v.done = 0;
      v.name = "rst_grant_ch2";
      apply(v);
      v.name = "rst_grant_hold";
      apply(v);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_async_clear", {sl1, sl2, grant, busy, done}, 8'b0);
      @(negedge clk);
      check("rst_no_done", {sl1, sl2, grant, busy, done}, 8'b0);
      rst_n = 1'b1;
      v.req = 4'b1111; v.dwell = 4'd1; v.sel = 0; v.grant = 4'b0001; v.busy = 1; v.done = 0;
      v.name = "rst_first_ch0";
      apply(v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_sel_scheduler.md
# mux_sel_scheduler

Round-robin select scheduler that drives the `sl1`/`sl2` select pair of the 4:1 mux stage directly downstream. It watches four channel request lines, grants one channel at a time in fair rotating order, and holds each grant for a programmable dwell time. All outputs are registered, so the mux sees glitch-free selects that change only on `clk` edges.

## Interface
- `DWELL_W`, default 4: width of the dwell-count input and the internal dwell counter.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `en` input 1: scheduler enable; new grants start only while high.
- `req` input 4: per-channel request, level-sensitive; bit i is channel i (mux input a/b/c/d for i=0/1/2/3).
- `dwell` input DWELL_W: grant length minus one, in cycles; sampled when a grant starts.
- `sl1` output 1: mux select MSB (channel index bit 1).
- `sl2` output 1: mux select LSB (channel index bit 0).
- `grant` output 4: one-hot grant, or all-zero when no channel is granted.
- `busy` output 1: high while any grant is active.
- `done` output 1: one-cycle pulse in the cycle after a grant ends, whether by normal completion or by abort.

## Operation
- Channel index is `{sl1,sl2}`: 0=a, 1=b, 2=c, 3=d. `grant` is always the one-hot decode of `{sl1,sl2}` while `busy`=1, and 4'b0000 otherwise.
- State machine:
  - IDLE → GRANT when `en`=1 and `req`≠0.
  - GRANT → GRANT (next channel) on normal completion when `en`=1 and some `req` is pending; there is no gap cycle.
  - GRANT → IDLE on completion when no request is pending or `en`=0.
  - GRANT → IDLE on abort.
- Arbitration: a 2-bit last-served pointer `last`. The winner is the first set `req` bit searching `last+1`, `last+2`, `last+3`, `last` (mod 4). On grant start, `last` becomes the winner.
- On grant start, the dwell counter loads `dwell`. The counter decrements each cycle in GRANT. The grant completes on the cycle the counter is 0. Total grant length is `dwell`+1 cycles; `dwell`=0 gives a 1-cycle grant, and the maximum is 2^DWELL_W cycles.
- Abort: if the granted channel's `req` is low at an edge during GRANT, the grant ends at that edge. `done` pulses, and the FSM goes to IDLE; it does not chain directly to another channel.
- `en` falling during GRANT does not cut the grant short. The current grant runs to completion, then the FSM goes to IDLE.
- When `busy`=0, `sl1`/`sl2` hold the last granted index so the mux output stays stable. Consumers qualify the mux output with `busy`.
- `dwell` changes during a grant have no effect until the next grant start.

## Timing
- Reset values (asynchronous, immediate on `rst_n` low): `sl1`=0, `sl2`=0, `grant`=0, `busy`=0, `done`=0, FSM=IDLE, counter=0, `last`=3. With `last`=3, channel 0 has first priority after reset.
- Grant latency: `req`/`en` sampled high at edge k → `grant`/`busy`/select valid after edge k (visible in cycle k+1).
- A grant of `dwell`=D occupies exactly D+1 consecutive cycles. `done` is high in the single cycle immediately after the last granted cycle.
- Back-to-back grants: the new select appears in the same cycle as the `done` pulse for the previous grant. `busy` stays high throughout.
- Abort completion also pulses `done` for one cycle. The next grant starts no earlier than the edge after that `done` cycle.
- Simultaneous normal completion and drop of the granted `req`: treat as normal completion. Arbitration excludes the dropped channel.
- `rst_n` asserted mid-grant: all outputs return to reset values immediately. No `done` pulse is generated.

## Test plan
- Reset then `req`=4'b1111, `en`=1, `dwell`=1 → grants cycle 0,1,2,3,0. Each grant lasts 2 cycles, `{sl1,sl2}` steps 0→1→2→3, and `done` pulses at each switch.
- `req`=4'b0100 only, `dwell`=3 → `grant`=4'b0100, `{sl1,sl2}`=2 for 4 cycles, then re-granted to channel 2 with no gap while `req` stays high.
- Abort: `dwell`=7 on channel 1, drop `req[1]` after the 3rd grant cycle → grant ends at that edge, `done`=1 for one cycle, then IDLE.
- Fairness: `last`=0, `req`=4'b1001 → channel 3 wins before channel 0; then `req`=4'b1011 → channel 0, then channel 1.
- `en` dropped mid-grant with `dwell`=4 → the full 5-cycle grant completes, then `busy`=0, `grant`=0, and `{sl1,sl2}` holds its value.
- `rst_n` pulsed low mid-grant → `sl1`/`sl2`/`grant`/`busy`/`done` read 0 before the next clock edge. After release with `req`=4'b1111, the first grant goes to channel 0.
